// File: rtl/palette_loader_pkg.sv
// Shared video definitions for palette loading: file formats, palette size,
// bytes per entry and the 5-bit to 8-bit colour channel expansion.
package palette_loader_pkg;

    typedef enum logic {
        PAL_FMT_RGB888 = 1'b0,
        PAL_FMT_BGR555 = 1'b1
    } pal_fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } pal_state_e;

    localparam int PAL_ENTRIES    = 64;
    localparam int PAL_BPE_RGB888 = 3;
    localparam int PAL_BPE_BGR555 = 2;

    // Replicate the top bits into the low bits so full scale maps to 0xFF.
    function automatic logic [7:0] pal_expand5(input logic [4:0] c5);
        return {c5, c5[4:2]};
    endfunction

endpackage

// File: rtl/pal_byte_packer.sv
// Collects download bytes into one palette entry. Tracks the byte phase,
// holds the partial bytes, and on the final byte of an entry emits a
// registered one-cycle {valid, rgb24} pulse. complete_o is the combinational
// "this byte finishes an entry" flag the top uses to advance its counter in
// lockstep with the pulse.
module pal_byte_packer
    import palette_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        restart_i,
    input  logic        flush_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    input  pal_fmt_e    fmt_i,
    output logic        complete_o,
    output logic        pix_valid_o,
    output logic [23:0] pix_rgb_o
);

    logic [1:0]  phase_q, phase_d;
    logic [1:0]  phase_cur;
    logic [1:0]  last_phase;
    logic [7:0]  b0_q, b1_q;
    logic        valid_q;
    logic [23:0] rgb_q, rgb_d;
    logic [14:0] word;

    // Phase bookkeeping and entry assembly; a restart treats the current byte as byte 0.
    always_comb begin
        phase_cur  = restart_i ? 2'd0 : phase_q;
        last_phase = (fmt_i == PAL_FMT_RGB888) ? 2'(PAL_BPE_RGB888 - 1)
                                               : 2'(PAL_BPE_BGR555 - 1);
        complete_o = byte_en_i && (phase_cur == last_phase);
        // Bit 15 of the 555 word carries no colour and is never looked at.
        word       = {byte_i[6:0], b0_q};
        if (fmt_i == PAL_FMT_RGB888) begin
            rgb_d = {b0_q, b1_q, byte_i};
        end else begin
            rgb_d = {pal_expand5(word[4:0]), pal_expand5(word[9:5]), pal_expand5(word[14:10])};
        end
        phase_d = phase_q;
        if (byte_en_i) begin
            phase_d = complete_o ? 2'd0 : phase_cur + 2'd1;
        end else if (restart_i || flush_i) begin
            phase_d = 2'd0;
        end
    end

    // Byte registers, phase and the registered output pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= 2'd0;
            b0_q    <= 8'd0;
            b1_q    <= 8'd0;
            valid_q <= 1'b0;
            rgb_q   <= 24'd0;
        end else begin
            phase_q <= phase_d;
            valid_q <= complete_o;
            if (complete_o) begin
                rgb_q <= rgb_d;
            end
            if (byte_en_i && (phase_cur == 2'd0)) begin
                b0_q <= byte_i;
            end
            if (byte_en_i && (phase_cur == 2'd1)) begin
                b1_q <= byte_i;
            end
        end
    end

    assign pix_valid_o = valid_q;
    assign pix_rgb_o   = rgb_q;

endmodule

// File: rtl/palette_loader.sv
// Streams a palette file from the download channel into the video palette
// RAM write port, and reports completion, truncation and overflow.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no download since reset
//   COLLECT | dl_active high, bytes being packed and written
//   FLUSH   | one cycle after dl_active fall; partial entry dropped
//   DONE    | flags hold the result until the next dl_active rise
module palette_loader
    import palette_loader_pkg::*;
#(
    parameter  int ENTRIES = PAL_ENTRIES,
    localparam int IDX_W   = $clog2(ENTRIES),
    localparam int CNT_W   = $clog2(ENTRIES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dl_active,
    input  logic             dl_wr,
    input  logic [7:0]       dl_data,
    input  logic             fmt,
    output logic             load_color,
    output logic [IDX_W-1:0] load_color_index,
    output logic [23:0]      load_color_data,
    output logic             busy,
    output logic             done,
    output logic             short_file,
    output logic             overflow,
    output logic [CNT_W-1:0] entries
);

    pal_state_e       state_q, state_d;
    logic             act_q;
    pal_fmt_e         fmt_q;
    pal_fmt_e         fmt_eff;
    logic [CNT_W-1:0] entries_q;
    logic [IDX_W-1:0] index_q;
    logic             done_q, short_q, ovf_q;

    logic rise, fall, start, collecting, full, byte_en, drop, flushing;
    logic pk_complete;

    assign rise       = dl_active & ~act_q;
    assign fall       = ~dl_active & act_q;
    assign start      = rise && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign collecting = (state_q == ST_COLLECT);
    assign flushing   = (state_q == ST_FLUSH);
    assign full       = (entries_q == CNT_W'(ENTRIES));
    // A strobe on the rising-edge cycle is byte 0 of the new file.
    assign byte_en    = dl_active && dl_wr && (start || (collecting && !full));
    assign drop       = dl_active && dl_wr && collecting && full;
    assign fmt_eff    = start ? pal_fmt_e'(fmt) : fmt_q;

    pal_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .restart_i  (start),
        .flush_i    (flushing),
        .byte_en_i  (byte_en),
        .byte_i     (dl_data),
        .fmt_i      (fmt_eff),
        .complete_o (pk_complete),
        .pix_valid_o(load_color),
        .pix_rgb_o  (load_color_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (rise) state_d = ST_COLLECT;
            ST_COLLECT: if (fall) state_d = ST_FLUSH;
            ST_FLUSH:   state_d = ST_DONE;
            ST_DONE:    if (rise) state_d = ST_COLLECT;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy = (state_q == ST_COLLECT) || (state_q == ST_FLUSH);
    end

    // Edge detect, format latch, entry counter, write index and result flags.
    // act_q resets high so a dl_active still high after reset is not a new rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_q     <= 1'b1;
            fmt_q     <= PAL_FMT_RGB888;
            entries_q <= '0;
            index_q   <= '0;
            done_q    <= 1'b0;
            short_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            act_q <= dl_active;
            if (start) begin
                fmt_q     <= pal_fmt_e'(fmt);
                entries_q <= '0;
                done_q    <= 1'b0;
                short_q   <= 1'b0;
                ovf_q     <= 1'b0;
            end
            if (pk_complete) begin
                index_q   <= entries_q[IDX_W-1:0];
                entries_q <= entries_q + 1'b1;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
            if (flushing) begin
                done_q  <= full;
                short_q <= ~full;
            end
        end
    end

    assign load_color_index = index_q;
    assign done             = done_q;
    assign short_file       = short_q;
    assign overflow         = ovf_q;
    assign entries          = entries_q;

endmodule

// File: tb/tb_palette_loader.sv
// Bench for palette_loader: a byte-level reference model predicts every
// palette write (cycle, index, data) and the end-of-download flags; literal
// expectations pin a few known values independently of the model.
module tb_palette_loader;

    logic        clk = 1'b0;
    logic        reset, dl_active, dl_wr, fmt;
    logic [7:0]  dl_data;
    logic        load_color;
    logic [5:0]  load_color_index;
    logic [23:0] load_color_data;
    logic        busy, done, short_file, overflow;
    logic [6:0]  entries;

    palette_loader dut (
        .clk             (clk),
        .reset           (reset),
        .dl_active       (dl_active),
        .dl_wr           (dl_wr),
        .dl_data         (dl_data),
        .fmt             (fmt),
        .load_color      (load_color),
        .load_color_index(load_color_index),
        .load_color_data (load_color_data),
        .busy            (busy),
        .done            (done),
        .short_file      (short_file),
        .overflow        (overflow),
        .entries         (entries)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          idx;
        logic [23:0] data;
    } wr_t;

    wr_t         expq[$];
    int          errors = 0;
    int          checks = 0;
    int          wr_total = 0;
    int          last_idx = -1;
    logic [23:0] seen[64];
    logic [7:0]  bytes[256];

    int          m_entries;
    bit          m_fmt;
    bit          m_ovf;
    logic [7:0]  m_buf[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ex5(input int c);
        return 8'((c << 3) | (c >> 2));
    endfunction

    task automatic model_start(input bit f);
        m_fmt     = f;
        m_entries = 0;
        m_ovf     = 0;
        m_buf.delete();
    endtask

    // Byte handed to the DUT this cycle; its entry (if completed) shows up next cycle.
    task automatic model_byte(input logic [7:0] b);
        int          bpe;
        int          w;
        logic [23:0] d;
        wr_t         e;
        bpe = m_fmt ? 2 : 3;
        if (m_entries == 64) begin
            m_ovf = 1;
            return;
        end
        m_buf.push_back(b);
        if (m_buf.size() == bpe) begin
            if (!m_fmt) begin
                d = {m_buf[0], m_buf[1], m_buf[2]};
            end else begin
                w = {m_buf[1], m_buf[0]};
                d = {ex5(w & 31), ex5((w >> 5) & 31), ex5((w >> 10) & 31)};
            end
            e.cyc  = cyc + 1;
            e.idx  = m_entries;
            e.data = d;
            expq.push_back(e);
            m_entries++;
            m_buf.delete();
        end
    endtask

    // Per-cycle comparison of the write port against the model queue.
    task automatic compare_cycle();
        wr_t e;
        while (expq.size() > 0 && expq[0].cyc < cyc) begin
            e = expq.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_write: index %0d expected at cycle %0d, not seen", e.idx, e.cyc);
        end
        if (load_color === 1'b1) begin
            wr_total++;
            last_idx = int'(load_color_index);
            seen[load_color_index] = load_color_data;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: index %0d data 0x%06h at cycle %0d, none required",
                         load_color_index, load_color_data, cyc);
            end else begin
                e = expq.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_index", load_color_index, e.idx);
                chk("wr_data", load_color_data, e.data);
                chk("wr_entries", entries, e.idx + 1);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_load_color"}, load_color, 0);
        chk({tag, "_index"}, load_color_index, 0);
        chk({tag, "_data"}, load_color_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_short"}, short_file, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_entries"}, entries, 0);
    endtask

    task automatic stray_strobes(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            dl_active = 0;
            dl_wr     = 1;
            dl_data   = 8'hA5;
        end
        tick();
        dl_wr = 0;
        tick();
    endtask

    // One whole download: first strobe rides the dl_active rise, gap idle cycles between bytes.
    task automatic download(input bit f, input int n, input int gap);
        model_start(f);
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == 1) chk("busy_mid", busy, 1);
            dl_active = 1;
            fmt       = f;
            dl_wr     = 1;
            dl_data   = bytes[i];
            model_byte(bytes[i]);
            for (int g = 0; g < gap; g++) begin
                tick();
                dl_wr = 0;
            end
        end
        tick();
        dl_wr     = 0;
        dl_active = 0;
        tick();
        tick();
        chk("end_done", done, (m_entries == 64) ? 1 : 0);
        chk("end_short", short_file, (m_entries == 64) ? 0 : 1);
        chk("end_overflow", overflow, m_ovf);
        chk("end_entries", entries, m_entries);
        chk("end_busy", busy, 0);
    endtask

    task automatic fill_rgb_pattern();
        for (int i = 0; i < 64; i++) begin
            bytes[3*i]   = 8'(i);
            bytes[3*i+1] = 8'(8'h80 + i);
            bytes[3*i+2] = 8'(8'hFF - i);
        end
    endtask

    initial begin
        int base;
        reset     = 1;
        dl_active = 0;
        dl_wr     = 0;
        dl_data   = 0;
        fmt       = 0;
        tick();
        tick();
        chk_zero("reset");
        reset = 0;

        // Strobes with dl_active low in IDLE.
        base = wr_total;
        stray_strobes(3);
        chk("idle_strobe_entries", entries, 0);
        chk("idle_strobe_writes", wr_total - base, 0);

        // Full RGB888 file.
        fill_rgb_pattern();
        base = wr_total;
        download(0, 192, 0);
        chk("rgb_writes", wr_total - base, 64);
        chk("rgb_last_idx", last_idx, 63);
        chk("rgb_entry5", seen[5], 24'h0585FA);
        chk("rgb_done_lit", done, 1);
        chk("rgb_entries_lit", entries, 64);

        // Strobes with dl_active low in DONE.
        base = wr_total;
        stray_strobes(3);
        chk("done_strobe_entries", entries, 64);
        chk("done_strobe_done", done, 1);
        chk("done_strobe_writes", wr_total - base, 0);

        // BGR555 primaries, with idle cycles between bytes.
        bytes[0] = 8'h1F; bytes[1] = 8'h00;
        bytes[2] = 8'hE0; bytes[3] = 8'h03;
        bytes[4] = 8'h00; bytes[5] = 8'h7C;
        base = wr_total;
        download(1, 6, 1);
        chk("bgr_writes", wr_total - base, 3);
        chk("bgr_red", seen[0], 24'hFF0000);
        chk("bgr_green", seen[1], 24'h00FF00);
        chk("bgr_blue", seen[2], 24'h0000FF);
        chk("bgr_short_lit", short_file, 1);
        chk("bgr_entries_lit", entries, 3);

        // Truncated RGB888 file.
        fill_rgb_pattern();
        base = wr_total;
        download(0, 100, 0);
        chk("short_writes", wr_total - base, 33);
        chk("short_last_idx", last_idx, 32);
        chk("short_flag_lit", short_file, 1);
        chk("short_done_lit", done, 0);
        chk("short_entries_lit", entries, 33);

        // Oversized RGB888 file.
        bytes[192] = 8'h11; bytes[193] = 8'h22; bytes[194] = 8'h33;
        base = wr_total;
        download(0, 195, 0);
        chk("ovf_writes", wr_total - base, 64);
        chk("ovf_last_idx", last_idx, 63);
        chk("ovf_flag_lit", overflow, 1);
        chk("ovf_done_lit", done, 1);

        // Reset mid-download, landing on the byte that would finish entry 16.
        base = wr_total;
        model_start(0);
        for (int i = 0; i < 50; i++) begin
            tick();
            dl_active = 1;
            fmt       = 0;
            dl_wr     = 1;
            dl_data   = bytes[i];
            model_byte(bytes[i]);
        end
        tick();
        dl_data = bytes[50];
        reset   = 1;
        tick();
        expq.delete();
        chk_zero("midreset");
        chk("midreset_writes", wr_total - base, 16);
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            dl_wr   = 1;
            dl_data = 8'h5A;
        end
        tick();
        dl_wr = 0;
        tick();
        chk("held_active_busy", busy, 0);
        chk("held_active_entries", entries, 0);
        chk("held_active_writes", wr_total - base, 16);
        dl_active = 0;
        tick();
        tick();

        base = wr_total;
        download(0, 192, 0);
        chk("redo_writes", wr_total - base, 64);
        chk("redo_last_idx", last_idx, 63);
        chk("redo_entry5", seen[5], 24'h0585FA);
        chk("redo_done_lit", done, 1);

        repeat (3) tick();
        chk("queue_drained", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/palette_loader.md
# palette_loader

Streams a user palette file from the ioctl download channel into the video block's 64-entry palette RAM by driving its `load_color` / `load_color_index` / `load_color_data` write port. It supports two file formats:
- RGB888: 192 bytes.
- BGR555 little-endian: 128 bytes, expanded to 24 bits.

It tracks progress, truncation and overflow so the menu can report a bad file. It sits between the top-level download mux and the video block, and palette selection 14 displays the result.

## Interface
Parameters:
- `ENTRIES`, 64: palette entries accepted; index width is clog2(ENTRIES).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high.
- `dl_active` in 1: level; high for the whole palette download.
- `dl_wr` in 1: one-cycle byte strobe; valid only while `dl_active`.
- `dl_data` in 8: download byte.
- `fmt` in 1: 0 = RGB888, 1 = BGR555 LE; sampled on the `dl_active` rising edge.
- `load_color` out 1: one-cycle palette RAM write strobe.
- `load_color_index` out 6: entry written.
- `load_color_data` out 24: {R,G,B}, 8 bits each.
- `busy` out 1: high from `dl_active` rise until the state returns to IDLE or DONE.
- `done` out 1: level; download finished with exactly `ENTRIES` entries.
- `short_file` out 1: level; download ended with fewer than `ENTRIES` complete entries.
- `overflow` out 1: level; bytes arrived after entry 63 completed.
- `entries` out 7: count of entries written in the current/last download (0..64).

## Operation
- States: IDLE, COLLECT, FLUSH, DONE.
- IDLE → COLLECT on `dl_active` rising edge. On that edge:
  - latch `fmt`;
  - clear byte phase, `entries`, `done`, `short_file`, `overflow`.
- COLLECT, per accepted `dl_wr`:
  - RGB888: phase 0/1/2 stores R/G/B.
  - BGR555: phase 0 stores the low byte, phase 1 the high byte; the word is [4:0]=R, [9:5]=G, [14:10]=B, bit 15 ignored.
  - Each 5-bit channel expands by replication, c8 = {c5, c5[4:2]}, so 0x1F → 0xFF and 0x00 → 0x00.
  - Completing the last phase registers data, issues the write (`index = entries[5:0]`), increments `entries` and resets phase.
- Once `entries == ENTRIES`, further `dl_wr` bytes are dropped and `overflow` is set. No write occurs, and the index does not wrap to 0.
- COLLECT → FLUSH on `dl_active` falling edge.
  - A partial entry (phase ≠ 0) is discarded, never written.
  - FLUSH lasts 1 cycle, so a write issued in the last COLLECT cycle completes.
  - FLUSH → DONE; `done = (entries == ENTRIES)`, `short_file = ~done`.
- DONE holds flags until the next `dl_active` rise, which behaves as the IDLE → COLLECT transition.
- `dl_wr` while `dl_active` is low is ignored in every state.
- `dl_wr` in the same cycle as the `dl_active` rising edge is accepted as byte 0.

## Timing
- Reset values: `load_color` 0, `load_color_index` 0, `load_color_data` 0, `busy` 0, `done` 0, `short_file` 0, `overflow` 0, `entries` 0, state IDLE.
- Write latency: `load_color` is high exactly 1 cycle, in the cycle after the `dl_wr` carrying an entry's final byte. Index and data are registered and stable in that cycle.
- Back-to-back `dl_wr` every cycle is supported; no backpressure. Minimum write spacing is 2 cycles (BGR555) or 3 cycles (RGB888).
- `entries` updates in the same cycle `load_color` is high.
- `done` / `short_file` are valid 2 cycles after the `dl_active` fall.
- Reset mid-download:
  - all outputs return to reset values next cycle and any pending write is cancelled;
  - a still-high `dl_active` does not restart the download until it falls and rises again.
- The video block muxes the RAM address on `load_color`, so a one-cycle pixel glitch during a load is accepted and not this block's concern.

## Structure
- Shared video package:
  - format enum (`PAL_FMT_RGB888`, `PAL_FMT_BGR555`);
  - `PAL_ENTRIES` = 64;
  - bytes-per-entry constants (3, 2);
  - the 5→8 expansion function (also usable by future 555 sources).
- One sub-module: `pal_byte_packer`. It covers phase counter, byte registers and format-dependent completion/expansion, and outputs a {valid, rgb24} pulse.
- Top level: FSM, index/entry counter, flags.

## Test plan
- RGB888, fmt=0, 192 bytes where entry i = {i, 0x80+i, 0xFF-i}, 1 byte/cycle:
  - 64 `load_color` pulses, index 0..63;
  - entry 5 data = 0x0585FA;
  - `done`=1, `short_file`=0, `overflow`=0, `entries`=64.
- BGR555, fmt=1, bytes 0x1F,0x00 then 0xE0,0x03 then 0x00,0x7C:
  - writes 0xFF0000 at index 0, 0x00FF00 at 1, 0x0000FF at 2;
  - at end, `short_file`=1, `entries`=3.
- RGB888 with 100 bytes:
  - 33 writes (index 0..32), last partial byte discarded;
  - `short_file`=1, `done`=0, `entries`=33.
- RGB888 with 195 bytes: 64 writes only, no write to index 0 after index 63; `overflow`=1, `done`=1.
- Reset asserted after 50 bytes, then a new 192-byte download:
  - all outputs 0 the cycle after reset;
  - no write issued for the reset-interrupted entry;
  - second download writes index 0..63 and `done`=1.
- `dl_wr` pulses with `dl_active` low in IDLE and DONE: no `load_color`, and `entries` unchanged.
